// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_scheduler
//  Purpose  : Matches alarms 1..3 against the time of day on each second tick,
//             queues matches and rings one alarm at a time for RING_SECS ticks.
//  Option   : ALARM_SNOOZE_EN adds a SNOOZE state lasting SNOOZE_SECS ticks.
//  Revision : 1.0
// ============================================================================
module alarm_scheduler #(
  parameter int unsigned RING_SECS   = 30,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  input  logic [2:0] mode,
  input  logic [5:0] alarm1_hour,
  input  logic [5:0] alarm1_minute,
  input  logic [5:0] alarm1_second,
  input  logic [5:0] alarm2_hour,
  input  logic [5:0] alarm2_minute,
  input  logic [5:0] alarm2_second,
  input  logic [5:0] alarm3_hour,
  input  logic [5:0] alarm3_minute,
  input  logic [5:0] alarm3_second,
  input  logic [2:0] alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring,
  output logic [1:0] ring_id,
  output logic [2:0] pending
);

  localparam logic [9:0] C_RING_LIM = 10'(RING_SECS);
  localparam logic [9:0] C_CNT_MAX  = 10'h3FF;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] C_SNZ_LIM  = 10'(SNOOZE_SECS);
  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1} state_t;
`endif

  state_t     state_q, state_d;
  logic [1:0] ring_id_q, ring_id_d;
  logic [2:0] pending_q, pending_d;
  logic [9:0] cnt_q, cnt_d;

  logic [5:0] w_hour [3];
  logic [5:0] w_min  [3];
  logic [5:0] w_sec  [3];
  logic [2:0] w_match;
  logic [2:0] w_avail;
  logic       w_cur_dis;
  logic [9:0] w_cnt_inc;

  assign w_hour[0] = alarm1_hour;  assign w_min[0] = alarm1_minute;  assign w_sec[0] = alarm1_second;
  assign w_hour[1] = alarm2_hour;  assign w_min[1] = alarm2_minute;  assign w_sec[1] = alarm2_second;
  assign w_hour[2] = alarm3_hour;  assign w_min[2] = alarm3_minute;  assign w_sec[2] = alarm3_second;

  for (genvar i = 0; i < 3; i++) begin : g_match
    localparam logic [2:0] C_SET_MODE = 3'(5 + i);
    localparam logic [1:0] C_ID       = 2'(i + 1);
    logic w_valid, w_mode_ok, w_eq, w_busy_self;
    assign w_valid     = (w_hour[i] < 6'd24) && (w_min[i] < 6'd60) && (w_sec[i] < 6'd60);
    assign w_mode_ok   = (mode != 3'd1) && (mode != 3'd2) && (mode != C_SET_MODE);
    assign w_eq        = (w_hour[i] == cur_hour) && (w_min[i] == cur_minute) &&
                         (w_sec[i] == cur_second);
    // The alarm already being serviced cannot re-queue itself.
    assign w_busy_self = (state_q != IDLE) && (ring_id_q == C_ID);
    assign w_match[i]  = sec_tick && alarm_en[i] && w_mode_ok && w_valid && w_eq && !w_busy_self;
  end

  assign w_avail   = pending_q & alarm_en;
  assign w_cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 10'd1;

  always_comb begin
    w_cur_dis = 1'b0;
    case (ring_id_q)
      2'd1:    w_cur_dis = !alarm_en[0];
      2'd2:    w_cur_dis = !alarm_en[1];
      2'd3:    w_cur_dis = !alarm_en[2];
      default: w_cur_dis = 1'b0;
    endcase
  end

`ifdef ALARM_SNOOZE_EN
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic [9:0] w_snz_inc;
  assign w_snz_inc = (snz_cnt_q == C_CNT_MAX) ? snz_cnt_q : snz_cnt_q + 10'd1;
`else
  logic unused_snooze;
  assign unused_snooze = snooze | (SNOOZE_SECS == 0);
`endif

  always_comb begin
    state_d   = state_q;
    ring_id_d = ring_id_q;
    cnt_d     = cnt_q;
    pending_d = (pending_q | w_match) & alarm_en;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d = snz_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_avail != 3'b000) begin
          state_d = RING;
          cnt_d   = 10'd0;
          if (w_avail[0]) begin
            ring_id_d    = 2'd1;
            pending_d[0] = 1'b0;
          end else if (w_avail[1]) begin
            ring_id_d    = 2'd2;
            pending_d[1] = 1'b0;
          end else begin
            ring_id_d    = 2'd3;
            pending_d[2] = 1'b0;
          end
        end
      end
      RING: begin
        if (w_cur_dis || stop) begin
          state_d   = IDLE;
          ring_id_d = 2'd0;
          cnt_d     = 10'd0;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_d   = SNOOZE;
          cnt_d     = 10'd0;
          snz_cnt_d = 10'd0;
`endif
        end else if (sec_tick) begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc >= C_RING_LIM) begin
            state_d   = IDLE;
            ring_id_d = 2'd0;
            cnt_d     = 10'd0;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (w_cur_dis || stop) begin
          state_d   = IDLE;
          ring_id_d = 2'd0;
          snz_cnt_d = 10'd0;
        end else if (sec_tick) begin
          snz_cnt_d = w_snz_inc;
          if (w_snz_inc >= C_SNZ_LIM) begin
            state_d   = RING;
            cnt_d     = 10'd0;
            snz_cnt_d = 10'd0;
          end
        end
      end
`endif
      default: begin
        state_d   = IDLE;
        ring_id_d = 2'd0;
        cnt_d     = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ring_id_q <= 2'd0;
      pending_q <= 3'b000;
      cnt_q     <= 10'd0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q <= 10'd0;
`endif
    end else begin
      state_q   <= state_d;
      ring_id_q <= ring_id_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q <= snz_cnt_d;
`endif
    end
  end

  assign ring    = (state_q == RING);
  assign ring_id = ring_id_q;
  assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_scheduler
//  Purpose  : Self-checking bench for alarm_scheduler (RING_SECS=30, SNOOZE_SECS=3).
//  Revision : 1.0
// ============================================================================
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic [5:0] cur_hour = '0, cur_minute = '0, cur_second = '0;
  logic [2:0] mode = '0;
  logic [5:0] a1h, a1m, a1s, a2h, a2m, a2s, a3h, a3m, a3s;
  logic [2:0] alarm_en = '0;
  logic       stop = 1'b0, snooze = 1'b0;
  logic       ring;
  logic [1:0] ring_id;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst, tick;
    logic [5:0] h, m, s;
    logic [2:0] mode, en;
    logic       stp, snz;
    logic       er;
    logic [1:0] eid;
    logic [2:0] ep;
  } vec_t;

  typedef struct packed {
    logic       r;
    logic [1:0] id;
    logic [2:0] p;
  } exp_t;

  exp_t sbq[$];
  vec_t tA[5];
  vec_t tB[13];

  alarm_scheduler #(.RING_SECS(30), .SNOOZE_SECS(3)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .mode(mode),
    .alarm1_hour(a1h), .alarm1_minute(a1m), .alarm1_second(a1s),
    .alarm2_hour(a2h), .alarm2_minute(a2m), .alarm2_second(a2s),
    .alarm3_hour(a3h), .alarm3_minute(a3m), .alarm3_second(a3s),
    .alarm_en(alarm_en), .stop(stop), .snooze(snooze),
    .ring(ring), .ring_id(ring_id), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic vec_t V(input logic r, input logic t, input int h, input int m, input int s,
                             input int md, input logic [2:0] en, input logic sp, input logic sz,
                             input logic er, input int eid, input logic [2:0] ep);
    vec_t v;
    v.rst = r;  v.tick = t;
    v.h = 6'(h); v.m = 6'(m); v.s = 6'(s);
    v.mode = 3'(md); v.en = en; v.stp = sp; v.snz = sz;
    v.er = er; v.eid = 2'(eid); v.ep = ep;
    return v;
  endfunction

  task automatic check(input string nm);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      if (ring !== e.r || ring_id !== e.id || pending !== e.p) begin
        errors++;
        $display("FAIL %s: got ring=%0b id=%0d pend=%b, expected ring=%0b id=%0d pend=%b",
                 nm, ring, ring_id, pending, e.r, e.id, e.p);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    rst = v.rst;  sec_tick = v.tick;
    cur_hour = v.h;  cur_minute = v.m;  cur_second = v.s;
    mode = v.mode;  alarm_en = v.en;  stop = v.stp;  snooze = v.snz;
    e.r = v.er;  e.id = v.eid;  e.p = v.ep;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  initial begin
    a1h = 7;  a1m = 30; a1s = 0;
    a2h = 8;  a2m = 15; a2s = 30;
    a3h = 20; a3m = 0;  a3s = 0;

    // Basic ring: reset, match at T, pending at T+1, ring at T+2
    tA[0] = V(1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0, 0, 3'b000);
    tA[1] = V(1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0, 0, 3'b000);
    tA[2] = V(0, 1, 7, 29, 59, 0, 3'b111, 0, 0, 0, 0, 3'b000);
    tA[3] = V(0, 1, 7, 30, 0, 0, 3'b001, 0, 0, 0, 0, 3'b001);
    tA[4] = V(0, 0, 7, 30, 0, 0, 3'b001, 0, 0, 1, 1, 3'b000);

    // Mode gating, disable mid-ring, disable of a pending alarm
    tB[0]  = V(0, 1, 8, 15, 30, 2, 3'b111, 0, 0, 0, 0, 3'b000);
    tB[1]  = V(0, 1, 8, 15, 30, 1, 3'b111, 0, 0, 0, 0, 3'b000);
    tB[2]  = V(0, 1, 8, 15, 30, 6, 3'b111, 0, 0, 0, 0, 3'b000);
    tB[3]  = V(0, 1, 8, 15, 30, 5, 3'b111, 0, 0, 0, 0, 3'b010);
    tB[4]  = V(0, 0, 8, 15, 30, 0, 3'b111, 0, 0, 1, 2, 3'b000);
    tB[5]  = V(0, 0, 8, 15, 30, 0, 3'b101, 0, 0, 0, 0, 3'b000);
    tB[6]  = V(0, 0, 8, 15, 30, 0, 3'b101, 0, 0, 0, 0, 3'b000);
    tB[7]  = V(0, 1, 8, 15, 30, 0, 3'b111, 0, 0, 0, 0, 3'b010);
    tB[8]  = V(0, 0, 8, 15, 30, 0, 3'b111, 0, 0, 1, 2, 3'b000);
    tB[9]  = V(0, 1, 20, 0, 0,  0, 3'b111, 0, 0, 1, 2, 3'b100);
    tB[10] = V(0, 0, 20, 0, 0,  0, 3'b011, 0, 0, 1, 2, 3'b000);
    tB[11] = V(0, 0, 20, 0, 0,  0, 3'b011, 1, 0, 0, 0, 3'b000);
    tB[12] = V(0, 0, 20, 0, 0,  0, 3'b011, 0, 0, 0, 0, 3'b000);

    for (int i = 0; i < 5; i++) apply(tA[i], $sformatf("basic[%0d]", i));
    for (int k = 1; k <= 30; k++)
      apply(V(0, 1, 7, 30, 1, 0, 3'b001, 0, 0, (k < 30), (k < 30) ? 1 : 0, 3'b000),
            $sformatf("ringtick[%0d]", k));

    for (int i = 0; i < 13; i++) apply(tB[i], $sformatf("gating[%0d]", i));

    // Out-of-range settings never match, even when equal to cur_*
    a2h = 8;  a2m = 60; a2s = 0;
    apply(V(0, 1, 8, 60, 0, 0, 3'b010, 0, 0, 0, 0, 3'b000), "range_min");
    a2h = 24; a2m = 15; a2s = 30;
    apply(V(0, 1, 24, 15, 30, 0, 3'b010, 0, 0, 0, 0, 3'b000), "range_hour");
    a2h = 8;

    // Simultaneous alarms 1 and 3; stop hands over to alarm 3
    a1h = 12; a1m = 0; a1s = 0;
    a3h = 12; a3m = 0; a3s = 0;
    apply(V(0, 1, 12, 0, 0, 0, 3'b111, 0, 0, 0, 0, 3'b101), "simul_match");
    apply(V(0, 0, 12, 0, 1, 0, 3'b111, 0, 0, 1, 1, 3'b100), "simul_ring1");
    apply(V(0, 0, 12, 0, 1, 0, 3'b111, 1, 0, 0, 0, 3'b100), "simul_stop");
    apply(V(0, 0, 12, 0, 1, 0, 3'b111, 0, 0, 1, 3, 3'b000), "simul_ring3");
    // Re-match while 3 rings: alarm 3 ignored, alarm 1 queued
    apply(V(0, 1, 12, 0, 0, 0, 3'b111, 0, 0, 1, 3, 3'b001), "rematch");
    a3h = 13;
    for (int k = 2; k <= 29; k++)
      apply(V(0, 1, 12, 0, 1, 0, 3'b111, 0, 0, 1, 3, 3'b001), $sformatf("ring3tick[%0d]", k));
    apply(V(0, 1, 12, 0, 1, 0, 3'b111, 1, 0, 0, 0, 3'b001), "stop_and_timeout");
    apply(V(0, 0, 12, 0, 1, 0, 3'b111, 0, 0, 1, 1, 3'b000), "next_pending");
    apply(V(1, 0, 12, 0, 1, 0, 3'b111, 0, 0, 0, 0, 3'b000), "reset_midring");
    apply(V(0, 0, 12, 0, 1, 0, 3'b001, 0, 0, 0, 0, 3'b000), "after_reset");

    // Snooze sequence
    apply(V(0, 1, 12, 0, 0, 0, 3'b001, 0, 0, 0, 0, 3'b001), "snz_match");
    apply(V(0, 0, 12, 0, 1, 0, 3'b001, 0, 0, 1, 1, 3'b000), "snz_ring");
`ifdef ALARM_SNOOZE_EN
    apply(V(0, 0, 12, 0, 1, 0, 3'b001, 0, 1, 0, 1, 3'b000), "snz_req");
    apply(V(0, 1, 12, 0, 1, 0, 3'b001, 0, 0, 0, 1, 3'b000), "snz_tick1");
    apply(V(0, 1, 12, 0, 2, 0, 3'b001, 0, 0, 0, 1, 3'b000), "snz_tick2");
    apply(V(0, 1, 12, 0, 3, 0, 3'b001, 0, 0, 1, 1, 3'b000), "snz_tick3");
    apply(V(0, 0, 12, 0, 3, 0, 3'b001, 0, 1, 0, 1, 3'b000), "snz_again");
`else
    apply(V(0, 0, 12, 0, 1, 0, 3'b001, 0, 1, 1, 1, 3'b000), "snz_req");
    apply(V(0, 1, 12, 0, 1, 0, 3'b001, 0, 0, 1, 1, 3'b000), "snz_tick1");
    apply(V(0, 1, 12, 0, 2, 0, 3'b001, 0, 0, 1, 1, 3'b000), "snz_tick2");
    apply(V(0, 1, 12, 0, 3, 0, 3'b001, 0, 0, 1, 1, 3'b000), "snz_tick3");
    apply(V(0, 0, 12, 0, 3, 0, 3'b001, 0, 1, 1, 1, 3'b000), "snz_again");
`endif
    apply(V(0, 0, 12, 0, 3, 0, 3'b001, 1, 0, 0, 0, 3'b000), "snz_stop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
